// File: rtl/exu_ctrl_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding,
// timeout default and the flag bundle latched in EXEC.
package exu_ctrl_pkg;

    localparam int EXU_STATE_WIDTH = 3;
    localparam int EXU_TIMEOUT     = 255;

    typedef enum logic [EXU_STATE_WIDTH-1:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_IWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_MREQ  = 3'd4,
        S_MWAIT = 3'd5,
        S_WB    = 3'd6,
        S_HALT  = 3'd7
    } exu_state_e;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic rd_wen;
        logic taken;
    } exu_flags_t;

    function automatic logic take_target(input exu_flags_t f);
        return f.jump | (f.branch & f.taken);
    endfunction

endpackage

// File: rtl/exu_ctrl_cnt.sv
// Performance counters (mcycle, minstret) and the bus-wait timeout counter.
module exu_ctrl_cnt #(
    parameter int CNT_WIDTH = 64,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cyc_en,
    input  logic                 ret,
    input  logic                 to_run,
    output logic [CNT_WIDTH-1:0] mcycle,
    output logic [CNT_WIDTH-1:0] minstret,
    output logic [TO_WIDTH-1:0]  to_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle   <= '0;
            minstret <= '0;
            to_cnt   <= '0;
        end else begin
            if (cyc_en) mcycle <= mcycle + CNT_WIDTH'(1);
            if (ret)    minstret <= minstret + CNT_WIDTH'(1);
            // Held at zero outside the wait states, so it starts fresh on every entry.
            to_cnt <= to_run ? to_cnt + TO_WIDTH'(1) : '0;
        end
    end

endmodule

// File: rtl/exu_ctrl.sv
// Multi-cycle sequencer: fetch / execute / memory / write-back, with halt on
// ebreak or bus timeout.
module exu_ctrl
    import exu_ctrl_pkg::*;
#(
    parameter int ISA_WIDTH = 32,
    parameter int CNT_WIDTH = 64,
    parameter int TIMEOUT   = EXU_TIMEOUT,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ifu_req_valid,
    input  logic                 ifu_req_ready,
    input  logic                 ifu_rsp_valid,
    output logic                 inst_we,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_branch,
    input  logic                 is_jump,
    input  logic                 is_ebreak,
    input  logic                 rd_wen,
    input  logic [ISA_WIDTH-1:0] alu_result,
    output logic                 lsu_req_valid,
    input  logic                 lsu_req_ready,
    output logic                 lsu_wen,
    input  logic                 lsu_rsp_valid,
    output logic                 reg_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 halt,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] mcycle,
    output logic [CNT_WIDTH-1:0] minstret
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    exu_state_e          state, state_nxt;
    exu_flags_t          flags_q;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                waiting, to_hit, timeout;
    logic                unused_bits;

    assign waiting     = (state == S_IWAIT) || (state == S_MWAIT);
    // Last wait cycle: a response arriving now still wins over the timeout.
    assign to_hit      = (to_cnt == TO_LAST);
    assign halt        = (state == S_HALT);
    assign unused_bits = ^{alu_result[ISA_WIDTH-1:1], flags_q.load};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            flags_q <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_EXEC) begin
                flags_q <= '{load:   is_load,
                             store:  is_store,
                             branch: is_branch,
                             jump:   is_jump,
                             rd_wen: rd_wen,
                             taken:  alu_result[0]};
            end
            if (timeout) err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        inst_we       = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        reg_we        = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        timeout       = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_nxt = S_IWAIT;
            end
            S_IWAIT: begin
                if (ifu_rsp_valid) begin
                    inst_we   = 1'b1;
                    state_nxt = S_EXEC;
                end else if (to_hit) begin
                    timeout   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_ebreak)                state_nxt = S_HALT;
                else if (is_load || is_store) state_nxt = S_MREQ;
                else                          state_nxt = S_WB;
            end
            S_MREQ: begin
                lsu_req_valid = 1'b1;
                lsu_wen       = flags_q.store;
                if (lsu_req_ready) state_nxt = S_MWAIT;
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    state_nxt = S_WB;
                end else if (to_hit) begin
                    timeout   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                pc_sel    = take_target(flags_q);
                reg_we    = flags_q.rd_wen & ~flags_q.store;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    exu_ctrl_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .TO_WIDTH  (TO_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cyc_en   (state != S_HALT),
        .ret      (pc_we),
        .to_run   (waiting),
        .mcycle   (mcycle),
        .minstret (minstret),
        .to_cnt   (to_cnt)
    );

endmodule

// File: tb/tb_exu_ctrl.sv
// Bench for exu_ctrl: per-instruction transaction model with random handshake
// delays and random decode noise outside EXEC.
module tb_exu_ctrl;

    localparam int ISA_WIDTH = 32;
    localparam int CNT_WIDTH = 64;
    localparam int TIMEOUT   = 255;
    localparam int TO_WIDTH  = 8;
    localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_LD = 3, K_ST = 4, K_EBRK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
    logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0;
    logic is_ebreak = 1'b0, rd_wen = 1'b0;
    logic [ISA_WIDTH-1:0] alu_result = '0;
    logic lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
    logic ifu_req_valid, inst_we, lsu_req_valid, lsu_wen, reg_we, pc_we, pc_sel, halt, err;
    logic [CNT_WIDTH-1:0] mcycle, minstret;

    int n_chk = 0;
    int n_err = 0;
    longint unsigned exp_cyc = 0;
    longint unsigned exp_ret = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    exu_ctrl #(
        .ISA_WIDTH (ISA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .TIMEOUT   (TIMEOUT),
        .TO_WIDTH  (TO_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .inst_we       (inst_we),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_branch     (is_branch),
        .is_jump       (is_jump),
        .is_ebreak     (is_ebreak),
        .rd_wen        (rd_wen),
        .alu_result    (alu_result),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_wen       (lsu_wen),
        .lsu_rsp_valid (lsu_rsp_valid),
        .reg_we        (reg_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .halt          (halt),
        .err           (err),
        .mcycle        (mcycle),
        .minstret      (minstret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the model's cycle count follows every live, non-halted edge.
    task automatic tick();
        @(posedge clk);
        if (rst && !m_halted) exp_cyc++;
        #1;
    endtask

    task automatic set_dec(input int kind, input bit rd, input bit tk);
        is_load    = (kind == K_LD);
        is_store   = (kind == K_ST);
        is_branch  = (kind == K_BR);
        is_jump    = (kind == K_JMP);
        is_ebreak  = (kind == K_EBRK);
        rd_wen     = rd;
        alu_result = {31'($urandom), tk};
    endtask

    task automatic noise_dec();
        {is_load, is_store, is_branch, is_jump, is_ebreak, rd_wen} = 6'($urandom);
        alu_result = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {ifu_req_valid, inst_we, lsu_req_valid, lsu_wen,
                             reg_we, pc_we, pc_sel, halt, err}, 0);
        chk({tag, "_mcycle"}, mcycle, 0);
        chk({tag, "_minstret"}, minstret, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_halted = 1'b0;
        exp_cyc  = 0;
        exp_ret  = 0;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("idle_no_req", ifu_req_valid, 0);
        tick();
        chk("fetch_after_idle", ifu_req_valid, 1);
        chk("mcycle_fetch", mcycle, exp_cyc);
    endtask

    // Entered with the DUT in FETCH; leaves it in FETCH (or HALT for ebreak).
    task automatic run_inst(input int kind, input bit rd, input bit tk,
                            input int d1, input int d2, input int d3, input int d4);
        bit mem;
        mem = (kind == K_LD) || (kind == K_ST);
        for (int i = 0; i <= d1; i++) begin
            ifu_req_ready = (i == d1);
            ifu_rsp_valid = 1'($urandom);
            #1;
            chk("fetch_req", ifu_req_valid, 1);
            chk("fetch_quiet", {inst_we, reg_we, pc_we, lsu_req_valid}, 0);
            tick();
        end
        ifu_req_ready = 1'b0;
        for (int i = 0; i <= d2; i++) begin
            ifu_rsp_valid = (i == d2);
            #1;
            chk("iwait_req", ifu_req_valid, 0);
            chk("inst_we", inst_we, (i == d2));
            chk("iwait_halt_err", {halt, err}, 0);
            tick();
        end
        ifu_rsp_valid = 1'b0;
        set_dec(kind, rd, tk);
        #1;
        chk("exec_quiet", {inst_we, reg_we, pc_we, ifu_req_valid, lsu_req_valid}, 0);
        tick();
        noise_dec();
        if (kind == K_EBRK) begin
            m_halted = 1'b1;
            #1;
            chk("ebreak_halt", {halt, err}, 2'b10);
            chk("ebreak_quiet", {pc_we, reg_we, ifu_req_valid}, 0);
            return;
        end
        if (mem) begin
            for (int i = 0; i <= d3; i++) begin
                lsu_req_ready = (i == d3);
                lsu_rsp_valid = 1'($urandom);
                ifu_rsp_valid = 1'($urandom);
                #1;
                chk("mreq_valid", lsu_req_valid, 1);
                chk("mreq_wen", lsu_wen, (kind == K_ST));
                chk("mreq_quiet", {inst_we, pc_we}, 0);
                tick();
            end
            lsu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            for (int i = 0; i <= d4; i++) begin
                lsu_rsp_valid = (i == d4);
                #1;
                chk("mwait_req", {lsu_req_valid, lsu_wen}, 0);
                chk("mwait_halt_err", {halt, err}, 0);
                tick();
            end
            lsu_rsp_valid = 1'b0;
        end
        chk("wb_pc_we", pc_we, 1);
        chk("wb_pc_sel", pc_sel, (kind == K_JMP) || (kind == K_BR && tk));
        chk("wb_reg_we", reg_we, rd && (kind != K_ST));
        chk("wb_minstret", minstret, exp_ret);
        tick();
        exp_ret++;
        chk("minstret", minstret, exp_ret);
        chk("mcycle", mcycle, exp_cyc);
        chk("back_to_fetch", ifu_req_valid, 1);
        chk("post_wb_quiet", {pc_we, reg_we}, 0);
    endtask

    initial begin
        #2;
        do_reset();

        // addi with ready and response one cycle late
        run_inst(K_ALU, 1'b1, 1'b0, 1, 1, 0, 0);
        // beq taken, then not taken
        run_inst(K_BR, 1'b0, 1'b1, 0, 0, 0, 0);
        run_inst(K_BR, 1'b0, 1'b0, 0, 0, 0, 0);
        // sw with lsu_req_ready late, then lw
        run_inst(K_ST, 1'b1, 1'b0, 0, 0, 3, 1);
        run_inst(K_LD, 1'b1, 1'b0, 0, 0, 0, 0);
        run_inst(K_JMP, 1'b1, 1'b0, 2, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_inst(int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // responses landing on the last allowed wait cycle must win
        run_inst(K_LD, 1'b1, 1'b0, 0, 0, 0, TIMEOUT - 1);
        run_inst(K_ALU, 1'b1, 1'b0, 0, TIMEOUT - 1, 0, 0);
        chk("boundary_no_err", {halt, err}, 0);

        // reset in the middle of a store request
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        tick();
        ifu_rsp_valid = 1'b0;
        set_dec(K_ST, 1'b0, 1'b0);
        tick();
        lsu_req_ready = 1'b0;
        #1;
        chk("mreq_before_reset", {lsu_req_valid, lsu_wen}, 2'b11);
        tick();
        #2;
        do_reset();
        run_inst(K_ALU, 1'b1, 1'b0, 0, 0, 0, 0);

        // ebreak halts; everything stays frozen afterwards
        run_inst(K_EBRK, 1'b1, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            ifu_req_ready = 1'($urandom);
            ifu_rsp_valid = 1'($urandom);
            lsu_req_ready = 1'($urandom);
            lsu_rsp_valid = 1'($urandom);
            noise_dec();
            tick();
            chk("halted_quiet", {ifu_req_valid, inst_we, lsu_req_valid, pc_we, reg_we}, 0);
            chk("halted_mcycle", mcycle, exp_cyc);
            chk("halted_flags", {halt, err}, 2'b10);
        end
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;

        // instruction response withheld: error halt after TIMEOUT wait cycles
        do_reset();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            chk("to_waiting", {halt, err, inst_we}, 0);
            tick();
        end
        m_halted = 1'b1;
        chk("to_halt_err", {halt, err}, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_frozen", mcycle, exp_cyc);
            chk("to_no_req", ifu_req_valid, 0);
        end
        chk("to_minstret", minstret, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
